rf215_iq_unpack: RTL and testbench



---
 rtl/rf215_pkg.sv | 46 ++++
 rtl/rf215_sync_fifo.sv | 58 +++++
 rtl/rf215_iq_unpack.sv | 94 +++++++++
 tb/tb_rf215_iq_unpack.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf215_pkg.sv
// Shared constants, field positions and the unpacked sample record for the
// RF215 IQ word unpacker.
package rf215_pkg;

  localparam logic [1:0] I_SYNC    = 2'b10;
  localparam logic [1:0] Q_SYNC    = 2'b01;
  localparam int         IQ_DATA_W = 13;
  localparam int         IQ_WORD_W = 32;

  // Bit positions inside the 32-bit receiver word
  localparam int I_SYNC_HI  = 31;
  localparam int I_SYNC_LO  = 30;
  localparam int I_DATA_HI  = 29;
  localparam int I_DATA_LO  = 17;
  localparam int I_CTRL_BIT = 16;
  localparam int Q_SYNC_HI  = 15;
  localparam int Q_SYNC_LO  = 14;
  localparam int Q_DATA_HI  = 13;
  localparam int Q_DATA_LO  = 1;
  localparam int Q_CTRL_BIT = 0;

  typedef struct packed {
    logic [IQ_DATA_W-1:0] i_data;
    logic                 i_ctrl;
    logic [IQ_DATA_W-1:0] q_data;
    logic                 q_ctrl;
  } rf215_iq_t;

  localparam int IQ_ENTRY_W = $bits(rf215_iq_t);

  // True when both sync fields carry their fixed patterns
  function automatic logic frame_ok(input logic [IQ_WORD_W-1:0] w);
    return (w[I_SYNC_HI:I_SYNC_LO] == I_SYNC) && (w[Q_SYNC_HI:Q_SYNC_LO] == Q_SYNC);
  endfunction

  // Strip the sync fields and keep data plus control bits
  function automatic rf215_iq_t unpack_word(input logic [IQ_WORD_W-1:0] w);
    rf215_iq_t r;
    r.i_data = w[I_DATA_HI:I_DATA_LO];
    r.i_ctrl = w[I_CTRL_BIT];
    r.q_data = w[Q_DATA_HI:Q_DATA_LO];
    r.q_ctrl = w[Q_CTRL_BIT];
    return r;
  endfunction

endpackage

// File: rtl/rf215_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rdata whenever empty is low; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module rf215_sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty     = (level_r == {(AW+1){1'b0}});
  assign full      = (level_r == (AW+1)'(DEPTH));
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally; occupancy tracked by its own counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/rf215_iq_unpack.sv
// RF215 IQ word unpacker: framing check, field split, sign extension,
// FWFT sample buffering and saturating fault statistics.
module rf215_iq_unpack
  import rf215_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                     rxclk,
  input  logic                     rst_n,
  input  logic [31:0]              iq_word,
  input  logic                     word_valid,
  input  logic                     enable,
  input  logic                     clear_stats,
  output logic [SAMPLE_W-1:0]      i_sample,
  output logic [SAMPLE_W-1:0]      q_sample,
  output logic                     i_ctrl,
  output logic                     q_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         fmt_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rf215_iq_t head_s;
  rf215_iq_t wr_entry_s;
  logic      accept_s;
  logic      good_s;
  logic      fmt_err_s;
  logic      pop_s;
  logic      full_s;
  logic      empty_s;
  logic      drop_s;

  assign accept_s   = word_valid && enable;
  assign good_s     = accept_s && frame_ok(iq_word);
  assign fmt_err_s  = accept_s && !frame_ok(iq_word);
  assign pop_s      = out_valid && out_ready;
  assign drop_s     = good_s && full_s && !pop_s;
  assign wr_entry_s = unpack_word(iq_word);
  assign out_valid  = !empty_s;

  rf215_sync_fifo #(
    .WIDTH (IQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rxclk),
    .rst_n (rst_n),
    .push  (good_s),
    .pop   (pop_s),
    .wdata (wr_entry_s),
    .rdata (head_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  // Head fields, sign-extended by replicating data bit 12
  always_comb begin
    i_sample = {{(SAMPLE_W-IQ_DATA_W){head_s.i_data[IQ_DATA_W-1]}}, head_s.i_data};
    q_sample = {{(SAMPLE_W-IQ_DATA_W){head_s.q_data[IQ_DATA_W-1]}}, head_s.q_data};
    i_ctrl   = head_s.i_ctrl;
    q_ctrl   = head_s.q_ctrl;
  end

  // Fault statistics; a clear wins over a same-cycle event
  always_ff @(posedge rxclk) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      drop_cnt    <= {CNT_W{1'b0}};
      fmt_err_cnt <= {CNT_W{1'b0}};
    end else if (clear_stats) begin
      overflow    <= 1'b0;
      drop_cnt    <= {CNT_W{1'b0}};
      fmt_err_cnt <= {CNT_W{1'b0}};
    end else begin
      if (fmt_err_s && (fmt_err_cnt != CNT_MAX)) begin
        fmt_err_cnt <= fmt_err_cnt + CNT_W'(1);
      end
      if (drop_s) begin
        overflow <= 1'b1;
        if (drop_cnt != CNT_MAX) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rf215_iq_unpack.sv
// Self-checking bench for rf215_iq_unpack: a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_rf215_iq_unpack;

  localparam int DEPTH    = 16;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 5;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic                rxclk = 1'b0;
  logic                rst_n;
  logic [31:0]         iq_word;
  logic                word_valid;
  logic                enable;
  logic                clear_stats;
  logic [SAMPLE_W-1:0] i_sample;
  logic [SAMPLE_W-1:0] q_sample;
  logic                i_ctrl;
  logic                q_ctrl;
  logic                out_valid;
  logic                out_ready;
  logic [LW-1:0]       level;
  logic                overflow;
  logic [CNT_W-1:0]    drop_cnt;
  logic [CNT_W-1:0]    fmt_err_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [27:0] mq[$];
  int          m_fmt;
  int          m_drop;
  bit          m_ovf;
  bit          m_pop;
  bit          m_push;
  bit          m_fe;
  bit          m_de;
  logic [27:0] m_head;

  rf215_iq_unpack #(
    .DEPTH    (DEPTH),
    .SAMPLE_W (SAMPLE_W),
    .CNT_W    (CNT_W)
  ) dut (
    .rxclk       (rxclk),
    .rst_n       (rst_n),
    .iq_word     (iq_word),
    .word_valid  (word_valid),
    .enable      (enable),
    .clear_stats (clear_stats),
    .i_sample    (i_sample),
    .q_sample    (q_sample),
    .i_ctrl      (i_ctrl),
    .q_ctrl      (q_ctrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .fmt_err_cnt (fmt_err_cnt)
  );

  always #5 rxclk = ~rxclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [12:0] i, input logic ic,
                                     input logic [12:0] q, input logic qc);
    return {2'b10, i, ic, 2'b01, q, qc};
  endfunction

  // Two's-complement value of a 13-bit field, expressed as a 16-bit pattern
  function automatic logic [15:0] sx(input logic [12:0] d);
    int v;
    v = int'(d);
    if (v >= 4096) v = v - 8192;
    return 16'(v);
  endfunction

  // Reference model: advance the sample queue and statistics on each edge
  always @(posedge rxclk) begin
    if (!rst_n) begin
      mq.delete();
      m_fmt  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = 1'b0;
      m_fe   = 1'b0;
      m_de   = 1'b0;
      if (word_valid && enable) begin
        if (iq_word[31:30] != 2'b10 || iq_word[15:14] != 2'b01) m_fe = 1'b1;
        else if (mq.size() == DEPTH && !m_pop) m_de = 1'b1;
        else m_push = 1'b1;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({iq_word[29:17], iq_word[16], iq_word[13:1], iq_word[0]});
      if (clear_stats) begin
        m_fmt  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
      end else begin
        if (m_fe && m_fmt < CMAX) m_fmt++;
        if (m_de) begin
          m_ovf = 1'b1;
          if (m_drop < CMAX) m_drop++;
        end
      end
    end
  end

  // Compare DUT outputs with the model away from the active edge
  always @(negedge rxclk) begin
    if (check_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("level", 32'(level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("fmt_err_cnt", 32'(fmt_err_cnt), 32'(m_fmt));
      if (mq.size() != 0) begin
        m_head = mq[0];
        chk("i_sample", 32'(i_sample), 32'(sx(m_head[27:15])));
        chk("i_ctrl", 32'(i_ctrl), 32'(m_head[14]));
        chk("q_sample", 32'(q_sample), 32'(sx(m_head[13:1])));
        chk("q_ctrl", 32'(q_ctrl), 32'(m_head[0]));
      end
    end
  end

  task automatic step();
    @(posedge rxclk);
    @(negedge rxclk);
  endtask

  function automatic logic [31:0] rnd_good();
    return mk(13'($urandom), 1'($urandom), 13'($urandom), 1'($urandom));
  endfunction

  initial begin
    rst_n       = 1'b0;
    iq_word     = 32'h0;
    word_valid  = 1'b0;
    enable      = 1'b1;
    clear_stats = 1'b0;
    out_ready   = 1'b0;
    step();
    step();
    check_en = 1'b1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fmt", 32'(fmt_err_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // First word into an empty FIFO
    iq_word = 32'h9FFC_4002; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    chk("w1_valid", 32'(out_valid), 32'd1);
    chk("w1_i", 32'(i_sample), 32'h0FFE);
    chk("w1_q", 32'(q_sample), 32'h0001);
    chk("w1_level", 32'(level), 32'd1);

    // Negative extremes with ctrl bits, popping the first word meanwhile
    iq_word = mk(13'h1000, 1'b1, 13'h1FFF, 1'b1); word_valid = 1'b1; out_ready = 1'b1;
    step();
    word_valid = 1'b0; out_ready = 1'b0;
    chk("neg_i", 32'(i_sample), 32'h0000_F000);
    chk("neg_q", 32'(q_sample), 32'h0000_FFFF);
    chk("neg_ictrl", 32'(i_ctrl), 32'd1);
    chk("neg_qctrl", 32'(q_ctrl), 32'd1);
    chk("neg_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Overfill by three
    for (int k = 0; k < DEPTH + 3; k++) begin
      iq_word = rnd_good(); word_valid = 1'b1;
      step();
    end
    word_valid = 1'b0;
    chk("ovf_level", 32'(level), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd3);

    // Push and pop while full
    iq_word = rnd_good(); word_valid = 1'b1; out_ready = 1'b1;
    step();
    word_valid = 1'b0;
    chk("fullpp_level", 32'(level), 32'(DEPTH));
    chk("fullpp_drop", 32'(drop_cnt), 32'd3);
    for (int k = 0; k < DEPTH; k++) step();
    out_ready = 1'b0;
    chk("drained", 32'(level), 32'd0);

    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // Framing errors
    iq_word = 32'h0000_0001; word_valid = 1'b1;
    step();
    iq_word = 32'h8000_0000;
    step();
    word_valid = 1'b0;
    chk("fmt_cnt", 32'(fmt_err_cnt), 32'd2);
    chk("fmt_level", 32'(level), 32'd0);
    iq_word = 32'h0000_0001; word_valid = 1'b1; clear_stats = 1'b1;
    step();
    word_valid = 1'b0; clear_stats = 1'b0;
    chk("fmt_clr", 32'(fmt_err_cnt), 32'd0);

    // Disabled input
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      iq_word = rnd_good(); word_valid = 1'b1;
      step();
    end
    word_valid = 1'b0; enable = 1'b1;
    chk("dis_level", 32'(level), 32'd0);

    // Counter saturation
    for (int k = 0; k < CMAX + 9; k++) begin
      iq_word = 32'h4000_8000 ^ 32'($urandom_range(0, 16'hFFFF)); word_valid = 1'b1;
      step();
    end
    word_valid = 1'b0;
    chk("sat_fmt", 32'(fmt_err_cnt), 32'(CMAX));
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      word_valid  = ($urandom_range(0, 3) != 0);
      iq_word     = ($urandom_range(0, 4) != 0) ? rnd_good() : 32'($urandom);
      enable      = ($urandom_range(0, 9) != 0);
      out_ready   = ($urandom_range(0, 2) != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (k % 500 > 250) out_ready = ($urandom_range(0, 3) == 0);
      clear_stats = ($urandom_range(0, 99) == 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1; word_valid = 1'b0; clear_stats = 1'b0; enable = 1'b1; out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Mid-stream reset with a word strobed in the reset cycle
    for (int k = 0; k < 7; k++) begin
      iq_word = rnd_good(); word_valid = 1'b1;
      step();
    end
    chk("pre_rst_level", 32'(level), 32'd7);
    rst_n = 1'b0; iq_word = rnd_good(); word_valid = 1'b1;
    step();
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; word_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
